// File: rtl/ex_stage.sv
// ex_stage: execute stage of a 5-stage integer pipeline.
// Selects operands with EX/MEM forwarding, evaluates the ALU, and holds the
// EX/MEM and MEM/WB pipeline registers. MUL runs on a 4-cycle byte-serial
// multiplier and stalls the ID stage through ex_ready.
// Ports:
//   clk, rstn                 clock, synchronous active-low reset
//   id_valid                  ID presents an instruction this cycle
//   id_regWrEn/id_regWrAddr   destination write enable / register
//   id_aluOp                  ALU operation code
//   id_aluSrc1/id_aluSrc2     operand select: 0 imm, 1 regfile, 2 EX, 3 MEM
//   id_rdata1/2, id_imm,id_pc operand sources and instruction PC
//   ex_ready                  EX can accept an instruction (FSM idle)
//   ex_regWrEn/Addr, ex_result    EX/MEM register (EX forwarding source)
//   mem_regWrEn/Addr, mem_result  MEM/WB register (MEM forwarding source)
//   ovf                       one-cycle pulse after an overflowing ADD
module ex_stage (
  input  logic        clk,
  input  logic        rstn,
  input  logic        id_valid,
  input  logic        id_regWrEn,
  input  logic [4:0]  id_regWrAddr,
  input  logic [3:0]  id_aluOp,
  input  logic [1:0]  id_aluSrc1,
  input  logic [1:0]  id_aluSrc2,
  input  logic [31:0] id_rdata1,
  input  logic [31:0] id_rdata2,
  input  logic [31:0] id_imm,
  input  logic [31:0] id_pc,
  output logic        ex_ready,
  output logic        ex_regWrEn,
  output logic [4:0]  ex_regWrAddr,
  output logic [31:0] ex_result,
  output logic        mem_regWrEn,
  output logic [4:0]  mem_regWrAddr,
  output logic [31:0] mem_result,
  output logic        ovf
);

  typedef enum logic [0:0] {IDLE = 1'b0, MUL_BUSY = 1'b1} state_t;

  localparam logic [3:0] OP_ADDU = 4'd0,  OP_SUBU = 4'd1,  OP_OR  = 4'd2,
                         OP_AND  = 4'd3,  OP_MUL  = 4'd4,  OP_SLT = 4'd5,
                         OP_XOR  = 4'd6,  OP_NOR  = 4'd7,  OP_SLL = 4'd8,
                         OP_SRL  = 4'd9,  OP_SRA  = 4'd10, OP_ADD = 4'd11,
                         OP_LINK = 4'd12;

  state_t      state_q, state_d;
  logic        ex_we_q, ex_we_d, mem_we_q, mem_we_d, ovf_q, ovf_d;
  logic [4:0]  ex_addr_q, ex_addr_d, mem_addr_q, mem_addr_d;
  logic [31:0] ex_res_q, ex_res_d, mem_res_q, mem_res_d;
  logic [31:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d, acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        mul_we_q, mul_we_d;
  logic [4:0]  mul_addr_q, mul_addr_d;

  logic [31:0] op1_s, op2_s, alu_s, sum_s, partial_s;
  logic [7:0]  mul_byte_s;
  logic        add_ovf_s, accept_s;

  // Operand mux; forwarded stages holding a bubble naturally supply 0.
  function automatic logic [31:0] sel_operand(input logic [1:0] src,
                                              input logic [31:0] rf,
                                              input logic [31:0] imm,
                                              input logic [31:0] ex_fwd,
                                              input logic [31:0] mem_fwd);
    case (src)
      2'd0:    sel_operand = imm;
      2'd1:    sel_operand = rf;
      2'd2:    sel_operand = ex_fwd;
      2'd3:    sel_operand = mem_fwd;
      default: sel_operand = 32'd0;
    endcase
  endfunction

  assign ex_ready      = (state_q == IDLE);
  assign ex_regWrEn    = ex_we_q;
  assign ex_regWrAddr  = ex_addr_q;
  assign ex_result     = ex_res_q;
  assign mem_regWrEn   = mem_we_q;
  assign mem_regWrAddr = mem_addr_q;
  assign mem_result    = mem_res_q;
  assign ovf           = ovf_q;

  // Operand selection and single-cycle ALU.
  always_comb begin
    op1_s     = sel_operand(id_aluSrc1, id_rdata1, id_imm, ex_res_q, mem_res_q);
    op2_s     = sel_operand(id_aluSrc2, id_rdata2, id_imm, ex_res_q, mem_res_q);
    sum_s     = op1_s + op2_s;
    add_ovf_s = (op1_s[31] == op2_s[31]) && (sum_s[31] != op1_s[31]);
    case (id_aluOp)
      OP_ADDU: alu_s = sum_s;
      OP_SUBU: alu_s = op1_s - op2_s;
      OP_OR:   alu_s = op1_s | op2_s;
      OP_AND:  alu_s = op1_s & op2_s;
      OP_SLT:  alu_s = ($signed(op1_s) < $signed(op2_s)) ? 32'd1 : 32'd0;
      OP_XOR:  alu_s = op1_s ^ op2_s;
      OP_NOR:  alu_s = ~(op1_s | op2_s);
      OP_SLL:  alu_s = op2_s << op1_s[4:0];
      OP_SRL:  alu_s = op2_s >> op1_s[4:0];
      OP_SRA:  alu_s = $signed(op2_s) >>> op1_s[4:0];
      OP_ADD:  alu_s = sum_s;
      OP_LINK: alu_s = id_pc + 32'd8;
      default: alu_s = 32'd0;
    endcase
  end

  // Next-state logic for the FSM, multiplier and both pipeline registers.
  always_comb begin
    // Byte-serial multiply: weight of byte cnt is 2^(8*cnt), truncated to 32 bits.
    mul_byte_s = mul_b_q[{cnt_q, 3'b000} +: 8];
    partial_s  = (mul_a_q * {24'd0, mul_byte_s}) << {cnt_q, 3'b000};
    accept_s   = id_valid && (state_q == IDLE);

    state_d    = state_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    mul_we_d   = mul_we_q;
    mul_addr_d = mul_addr_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ex_we_d    = 1'b0;
    ex_addr_d  = 5'd0;
    ex_res_d   = 32'd0;
    ovf_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (accept_s && (id_aluOp == OP_MUL)) begin
          mul_a_d    = op1_s;
          mul_b_d    = op2_s;
          mul_we_d   = id_regWrEn;
          mul_addr_d = id_regWrAddr;
          acc_d      = 32'd0;
          cnt_d      = 2'd0;
          state_d    = MUL_BUSY;
        end else if (accept_s) begin
          // An overflowing ADD still writes the wrapped sum but never commits.
          ex_we_d   = id_regWrEn && !((id_aluOp == OP_ADD) && add_ovf_s);
          ex_addr_d = id_regWrAddr;
          ex_res_d  = alu_s;
          ovf_d     = (id_aluOp == OP_ADD) && add_ovf_s;
        end else begin
          state_d = IDLE;
        end
      end
      MUL_BUSY: begin
        acc_d = acc_q + partial_s;
        cnt_d = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          ex_we_d   = mul_we_q;
          ex_addr_d = mul_addr_q;
          ex_res_d  = acc_q + partial_s;
          state_d   = IDLE;
        end else begin
          state_d = MUL_BUSY;
        end
      end
      default: state_d = IDLE;
    endcase

    mem_we_d   = ex_we_q;
    mem_addr_d = ex_addr_q;
    mem_res_d  = ex_res_q;
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ex_we_q    <= 1'b0;
      ex_addr_q  <= 5'd0;
      ex_res_q   <= 32'd0;
      mem_we_q   <= 1'b0;
      mem_addr_q <= 5'd0;
      mem_res_q  <= 32'd0;
      ovf_q      <= 1'b0;
      mul_a_q    <= 32'd0;
      mul_b_q    <= 32'd0;
      mul_we_q   <= 1'b0;
      mul_addr_q <= 5'd0;
      acc_q      <= 32'd0;
      cnt_q      <= 2'd0;
    end else begin
      state_q    <= state_d;
      ex_we_q    <= ex_we_d;
      ex_addr_q  <= ex_addr_d;
      ex_res_q   <= ex_res_d;
      mem_we_q   <= mem_we_d;
      mem_addr_q <= mem_addr_d;
      mem_res_q  <= mem_res_d;
      ovf_q      <= ovf_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_we_q   <= mul_we_d;
      mul_addr_q <= mul_addr_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
    end
  end

endmodule
